pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake. It generalises the fixed-field stage registers between pipeline stages (e.g. MEM→WB) to any payload width. It adds back-pressure, an optional 2-entry skid buffer that breaks the combinational ready path, synchronous flush and a saturating stall counter. It sits between any two core stages; the upstream stage packs its fields into `in_data` and the downstream stage unpacks `out_data`.

---
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating stall counter.
module pipe_stage_skid #(
  parameter int unsigned DATA_W  = 32,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              main_v;
  logic              skid_v;
  logic              in_fire;
  logic              out_fire;
  logic              load_main;
  logic              load_skid;
  logic              pop_skid;

  // State register; FULL is only reachable when the skid entry exists
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: flush empties the stage regardless of handshakes
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) state_nxt = ONE;
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state_nxt = SKID_EN ? FULL : ONE;
          end else if (!in_fire && out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Outputs and datapath controls decoded from state and handshakes
  always_comb begin
    main_v    = 1'b0;
    skid_v    = 1'b0;
    occupancy = 2'd0;
    in_ready  = 1'b0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      ONE: begin
        main_v    = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        main_v    = 1'b1;
        skid_v    = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
    // Skid mode: ready depends only on held state, never on out_ready
    in_ready  = SKID_EN ? !skid_v : (!main_v || out_ready);
    in_fire   = in_valid && in_ready && !flush;
    out_fire  = main_v && out_ready;
    load_main = in_fire && ((state == EMPTY) || ((state == ONE) && out_fire));
    load_skid = SKID_EN && in_fire && (state == ONE) && !out_fire;
    pop_skid  = !flush && (state == FULL) && out_fire;
  end

  // Payload registers; flush leaves stale data in place
  always_ff @(posedge clk) begin
    if (reset) begin
      main_d <= '0;
      skid_d <= '0;
    end else begin
      if (pop_skid) begin
        main_d <= skid_d;
      end else if (load_main) begin
        main_d <= in_data;
      end
      if (load_skid) begin
        skid_d <= in_data;
      end
    end
  end

  // Saturating count of cycles where a held entry is refused downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid = main_v;
  assign out_data  = main_d;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: skid mode, single-register mode and
// a narrow stall counter, each on its own instance.
module tb_pipe_stage_skid;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  // Skid-mode instance
  logic          flush1, iv1, ir1, ov1, or1;
  logic [DW-1:0] id1, od1;
  logic [1:0]    occ1;
  logic [15:0]   sc1;
  // Single-register instance
  logic          flush0, iv0, ir0, ov0, or0;
  logic [DW-1:0] id0, od0;
  logic [1:0]    occ0;
  logic [15:0]   sc0;
  // Narrow-counter instance
  logic          flush3, iv3, ir3, ov3, or3;
  logic [DW-1:0] id3, od3;
  logic [1:0]    occ3;
  logic [2:0]    sc3;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .occupancy(occ1), .stall_cnt(sc1));

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .occupancy(occ0), .stall_cnt(sc0));

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .occupancy(occ3), .stall_cnt(sc3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the skid instance: every out-fire must match the queue head
  always @(negedge clk) begin
    if (reset === 1'b0 && flush1 === 1'b0 && ov1 === 1'b1 && or1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_unexpected: got %0h required none", od1);
      end else begin
        chk("d1_out", 32'(od1), 32'(q1.pop_front()));
      end
    end
  end

  // Monitor for the single-register instance
  always @(negedge clk) begin
    if (reset === 1'b0 && flush0 === 1'b0 && ov0 === 1'b1 && or0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d0_unexpected: got %0h required none", od0);
      end else begin
        chk("d0_out", 32'(od0), 32'(q0.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1;
    flush1 = 1'b0; flush0 = 1'b0; flush3 = 1'b0;
    iv1 = 1'b1; id1 = 16'hDEAD; or1 = 1'b1;
    iv0 = 1'b1; id0 = 16'hDEAD; or0 = 1'b1;
    iv3 = 1'b0; id3 = '0;       or3 = 1'b1;
    step();
    step();
    // Reset values with an offer present
    chk("rst_ov1", 32'(ov1), 32'd0);
    chk("rst_od1", 32'(od1), 32'd0);
    chk("rst_occ1", 32'(occ1), 32'd0);
    chk("rst_sc1", 32'(sc1), 32'd0);
    chk("rst_ir1", 32'(ir1), 32'd1);
    chk("rst_ov0", 32'(ov0), 32'd0);
    reset = 1'b0; iv1 = 1'b0; iv0 = 1'b0;
    step();
    chk("post_rst_ir1", 32'(ir1), 32'd1);
    chk("post_rst_ov1", 32'(ov1), 32'd0);
    chk("post_rst_ov0", 32'(ov0), 32'd0);

    // Streaming through the skid instance
    for (int i = 1; i <= 3; i++) begin
      iv1 = 1'b1; id1 = DW'(i); q1.push_back(DW'(i));
      step();
      chk("stream1_occ", 32'(occ1), 32'd1);
      chk("stream1_sc", 32'(sc1), 32'd0);
    end
    iv1 = 1'b0;
    step();
    chk("stream1_drain_ov", 32'(ov1), 32'd0);

    // Back-pressure fills main then skid
    or1 = 1'b0;
    iv1 = 1'b1; id1 = 16'h000A; q1.push_back(16'h000A);
    step();
    chk("bp_occ_one", 32'(occ1), 32'd1);
    chk("bp_ir_one", 32'(ir1), 32'd1);
    id1 = 16'h000B; q1.push_back(16'h000B);
    step();
    chk("bp_occ_full", 32'(occ1), 32'd2);
    chk("bp_ir_full", 32'(ir1), 32'd0);
    chk("bp_head", 32'(od1), 32'h000A);
    chk("bp_sc", 32'(sc1), 32'd1);
    iv1 = 1'b0; or1 = 1'b1;
    step();
    chk("bp_occ_drain", 32'(occ1), 32'd1);
    chk("bp_ir_back", 32'(ir1), 32'd1);
    chk("bp_head2", 32'(od1), 32'h000B);
    chk("bp_sc_hold", 32'(sc1), 32'd1);
    step();
    chk("bp_empty_ov", 32'(ov1), 32'd0);
    chk("bp_empty_occ", 32'(occ1), 32'd0);

    // Flush while FULL with a new offer present
    or1 = 1'b0;
    iv1 = 1'b1; id1 = 16'h000A; q1.push_back(16'h000A);
    step();
    id1 = 16'h000B; q1.push_back(16'h000B);
    step();
    chk("fl_occ_full", 32'(occ1), 32'd2);
    flush1 = 1'b1; id1 = 16'h000C;
    step();
    q1.delete();
    flush1 = 1'b0; iv1 = 1'b0;
    chk("fl_ov", 32'(ov1), 32'd0);
    chk("fl_occ", 32'(occ1), 32'd0);
    chk("fl_ir", 32'(ir1), 32'd1);
    chk("fl_sc", 32'(sc1), 32'd3);
    or1 = 1'b1;
    step();
    step();
    chk("fl_no_c", 32'(ov1), 32'd0);
    iv1 = 1'b1; id1 = 16'h0007; q1.push_back(16'h0007);
    step();
    iv1 = 1'b0;
    chk("fl_recover", 32'(od1), 32'h0007);
    step();

    // Streaming through the single-register instance
    for (int i = 1; i <= 3; i++) begin
      iv0 = 1'b1; id0 = DW'(i); q0.push_back(DW'(i));
      step();
      chk("stream0_occ", 32'(occ0), 32'd1);
      chk("stream0_ir", 32'(ir0), 32'd1);
    end
    iv0 = 1'b0;
    step();
    chk("stream0_drain_ov", 32'(ov0), 32'd0);

    // Single-register hold and same-cycle ready
    or0 = 1'b0;
    iv0 = 1'b1; id0 = 16'h0005; q0.push_back(16'h0005);
    step();
    iv0 = 1'b0;
    chk("hold0_ir", 32'(ir0), 32'd0);
    chk("hold0_occ", 32'(occ0), 32'd1);
    step();
    chk("hold0_data", 32'(od0), 32'h0005);
    or0 = 1'b1; iv0 = 1'b1; id0 = 16'h0006; q0.push_back(16'h0006);
    #1;
    chk("comb0_ir", 32'(ir0), 32'd1);
    step();
    iv0 = 1'b0;
    chk("next0_data", 32'(od0), 32'h0006);
    chk("next0_occ", 32'(occ0), 32'd1);
    chk("next0_sc", 32'(sc0), 32'd1);
    step();
    chk("next0_drain", 32'(ov0), 32'd0);

    // Narrow counter saturates at 7
    or3 = 1'b0;
    iv3 = 1'b1; id3 = 16'h0011;
    step();
    iv3 = 1'b0;
    chk("sat_ov", 32'(ov3), 32'd1);
    chk("sat_data", 32'(od3), 32'h0011);
    chk("sat_start", 32'(sc3), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("sat_cnt", 32'(sc3), (i > 7) ? 32'd7 : 32'(i));
    end
    flush3 = 1'b1;
    step();
    flush3 = 1'b0;
    chk("sat_flush_ov", 32'(ov3), 32'd0);
    chk("sat_flush_cnt", 32'(sc3), 32'd7);

    step();
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
